i2c_ram_arbiter: RTL and testbench

Shares the single port of the I2C register RAM between two requesters: the I2C slave FSM (port S), which must never be stalled because it is clocked by the bus, and a local host (port H) with a request/grant handshake. Port S always wins, and port H gets every idle RAM cycle. The block routes registered RAM read data back to whichever port issued the read. It also flags host starvation when I2C traffic monopolises the RAM.

---
 rtl/i2c_ram_arbiter.sv | 151 +++++++++++++++
 tb/tb_i2c_ram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_ram_arbiter.sv
// i2c_ram_arbiter
// Shares the single RAM port between the bus-clocked I2C slave FSM (port S)
// and a local host (port H). The slave always wins and is never stalled. The
// host is granted every cycle the slave leaves idle. Registered RAM read data
// is steered back to whichever port issued the read. A saturating counter
// reports when the host has been kept waiting too long.

module i2c_ram_arbiter #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 8,
  parameter int CNT_W        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock_in,
  input  logic              reset_in,

  input  logic              s_wr_en_in,
  input  logic              s_rd_en_in,
  input  logic [ADDR_W-1:0] s_addr_in,
  input  logic [DATA_W-1:0] s_data_in,
  output logic [DATA_W-1:0] s_data_out,

  input  logic              h_req_in,
  input  logic              h_we_in,
  input  logic [ADDR_W-1:0] h_addr_in,
  input  logic [DATA_W-1:0] h_wdata_in,
  output logic              h_gnt_out,
  output logic [DATA_W-1:0] h_rdata_out,
  output logic              h_rvalid_out,
  output logic              h_starve_out,

  output logic              ram_wr_en_out,
  output logic              ram_rd_en_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic [DATA_W-1:0] ram_data_out,
  input  logic [DATA_W-1:0] ram_data_in
);

  // The read-return state records which port owns the RAM data arriving
  // this cycle (the RAM returns data one clock after its read strobe).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_S = 2'd1,
    RD_H = 2'd2
  } rdState_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  rdState_e          state_q, state_d;
  logic [DATA_W-1:0] sData_q, sData_d;
  logic [DATA_W-1:0] hData_q, hData_d;
  logic [CNT_W-1:0]  starveCnt_q, starveCnt_d;
  logic              starve_q, starve_d;

  logic slaveActive;
  logic slaveRead;
  logic hostGrant;
  logic hostRead;

  // Request decode: a simultaneous write+read strobe from the slave is a
  // write only; the host is granted only on slave-idle cycles outside reset.
  always_comb begin
    slaveActive = s_wr_en_in | s_rd_en_in;
    slaveRead   = s_rd_en_in & ~s_wr_en_in;
    hostGrant   = reset_in & ~slaveActive & h_req_in;
    hostRead    = hostGrant & ~h_we_in;
  end

  // RAM port mux: slave has zero added latency, host fills idle cycles.
  // Address/data default to the host values when nobody is accessing.
  always_comb begin
    ram_wr_en_out = 1'b0;
    ram_rd_en_out = 1'b0;
    ram_addr_out  = h_addr_in;
    ram_data_out  = h_wdata_in;
    if (reset_in) begin
      if (slaveActive) begin
        ram_wr_en_out = s_wr_en_in;
        ram_rd_en_out = slaveRead;
        ram_addr_out  = s_addr_in;
        ram_data_out  = s_data_in;
      end else begin
        ram_wr_en_out = hostGrant & h_we_in;
        ram_rd_en_out = hostRead;
      end
    end
  end

  // Next read-return owner follows the read issued this cycle, so
  // back-to-back reads chain RD_x -> RD_y without an idle bubble.
  always_comb begin
    state_d = IDLE;
    if (slaveRead) begin
      state_d = RD_S;
    end else if (hostRead) begin
      state_d = RD_H;
    end
  end

  // Held read-data registers capture the RAM word in their return cycle.
  always_comb begin
    sData_d = sData_q;
    hData_d = hData_q;
    case (state_q)
      RD_S:    sData_d = ram_data_in;
      RD_H:    hData_d = ram_data_in;
      default: ;
    endcase
  end

  // Starvation counter: counts consecutive cycles the host waits, saturating,
  // and clears on any grant or when the host stops requesting. The flag is
  // registered from the updated count so it is aligned with the counter.
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (!h_req_in || hostGrant) begin
      starveCnt_d = '0;
    end else if (starveCnt_q != CNT_MAX) begin
      starveCnt_d = starveCnt_q + 1'b1;
    end
    starve_d = (starveCnt_d >= CNT_LIMIT);
  end

  // State and held-data registers; reset drops any pending read return.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q     <= IDLE;
      sData_q     <= '0;
      hData_q     <= '0;
      starveCnt_q <= '0;
      starve_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sData_q     <= sData_d;
      hData_q     <= hData_d;
      starveCnt_q <= starveCnt_d;
      starve_q    <= starve_d;
    end
  end

  // Read data is forwarded straight from the RAM in the return cycle and
  // held from the register afterwards, so each port sees its word one clock
  // after the strobe.
  assign s_data_out   = (state_q == RD_S) ? ram_data_in : sData_q;
  assign h_rdata_out  = (state_q == RD_H) ? ram_data_in : hData_q;
  assign h_rvalid_out = (state_q == RD_H);
  assign h_gnt_out    = hostGrant;
  assign h_starve_out = starve_q;

endmodule

// File: tb/tb_i2c_ram_arbiter.sv
// tb_i2c_ram_arbiter
// Directed stimulus for the I2C RAM arbiter with a behavioural reference
// model of the priority rules, the read-return routing and the host wait
// history, plus hand-computed spot checks.

module tb_i2c_ram_arbiter;

  localparam int ADDR_W       = 7;
  localparam int DATA_W       = 8;
  localparam int CNT_W        = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int WAIT_MAX     = (1 << CNT_W) - 1;

  logic              clock_in    = 1'b0;
  logic              reset_in    = 1'b1;
  logic              s_wr_en_in  = 1'b0;
  logic              s_rd_en_in  = 1'b0;
  logic [ADDR_W-1:0] s_addr_in   = '0;
  logic [DATA_W-1:0] s_data_in   = '0;
  logic              h_req_in    = 1'b0;
  logic              h_we_in     = 1'b0;
  logic [ADDR_W-1:0] h_addr_in   = '0;
  logic [DATA_W-1:0] h_wdata_in  = '0;
  logic [DATA_W-1:0] ram_data_in = '0;

  logic [DATA_W-1:0] s_data_out;
  logic              h_gnt_out;
  logic [DATA_W-1:0] h_rdata_out;
  logic              h_rvalid_out;
  logic              h_starve_out;
  logic              ram_wr_en_out;
  logic              ram_rd_en_out;
  logic [ADDR_W-1:0] ram_addr_out;
  logic [DATA_W-1:0] ram_data_out;

  int compared   = 0;
  int mismatched = 0;

  bit [DATA_W-1:0] ramMem [1 << ADDR_W];
  bit [DATA_W-1:0] expMem [1 << ADDR_W];

  i2c_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock_in     (clock_in),
    .reset_in     (reset_in),
    .s_wr_en_in   (s_wr_en_in),
    .s_rd_en_in   (s_rd_en_in),
    .s_addr_in    (s_addr_in),
    .s_data_in    (s_data_in),
    .s_data_out   (s_data_out),
    .h_req_in     (h_req_in),
    .h_we_in      (h_we_in),
    .h_addr_in    (h_addr_in),
    .h_wdata_in   (h_wdata_in),
    .h_gnt_out    (h_gnt_out),
    .h_rdata_out  (h_rdata_out),
    .h_rvalid_out (h_rvalid_out),
    .h_starve_out (h_starve_out),
    .ram_wr_en_out(ram_wr_en_out),
    .ram_rd_en_out(ram_rd_en_out),
    .ram_addr_out (ram_addr_out),
    .ram_data_out (ram_data_out),
    .ram_data_in  (ram_data_in)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock_in = ~clock_in;

  // Single-port RAM with a registered read, driven only by the DUT strobes.
  always @(posedge clock_in) begin
    if (ram_wr_en_out) ramMem[ram_addr_out] <= ram_data_out;
    if (ram_rd_en_out) ram_data_in <= ramMem[ram_addr_out];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic sWr, input logic sRd, input logic [ADDR_W-1:0] sAddr,
                               input logic [DATA_W-1:0] sData, input logic hReq, input logic hWe,
                               input logic [ADDR_W-1:0] hAddr, input logic [DATA_W-1:0] hWdata);
    @(posedge clock_in);
    #1;
    s_wr_en_in = sWr;
    s_rd_en_in = sRd;
    s_addr_in  = sAddr;
    s_data_in  = sData;
    h_req_in   = hReq;
    h_we_in    = hWe;
    h_addr_in  = hAddr;
    h_wdata_in = hWdata;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Reference model: each cycle decide who owns the RAM from the request
  // rules, remember what each issued read must return next cycle, and track
  // how many consecutive cycles the host has been left waiting.
  always begin : model
    logic            live, slaveOn, mGnt, mWr, mRd, mSlaveRead, mHostRead;
    logic [ADDR_W-1:0] mAddr;
    logic [DATA_W-1:0] mData;
    logic            pendS, pendH;
    logic [DATA_W-1:0] pendSVal, pendHVal, heldS, heldH;
    int              waitCnt;

    @(negedge clock_in);
    live = reset_in;
    if (!reset_in) begin
      pendS = 1'b0; pendH = 1'b0; heldS = '0; heldH = '0; waitCnt = 0;
      mWr = 1'b0; mSlaveRead = 1'b0; mHostRead = 1'b0; mGnt = 1'b0;
      checkOutput("mdl_rst_gnt", h_gnt_out, 0);
      checkOutput("mdl_rst_wr", ram_wr_en_out, 0);
      checkOutput("mdl_rst_rd", ram_rd_en_out, 0);
      checkOutput("mdl_rst_sdata", s_data_out, 0);
      checkOutput("mdl_rst_hdata", h_rdata_out, 0);
      checkOutput("mdl_rst_rvalid", h_rvalid_out, 0);
      checkOutput("mdl_rst_starve", h_starve_out, 0);
    end else begin
      slaveOn    = s_wr_en_in || s_rd_en_in;
      mGnt       = !slaveOn && h_req_in;
      mSlaveRead = s_rd_en_in && !s_wr_en_in;
      mHostRead  = mGnt && !h_we_in;
      mWr        = s_wr_en_in || (mGnt && h_we_in);
      mRd        = mSlaveRead || mHostRead;
      mAddr      = slaveOn ? s_addr_in : h_addr_in;
      mData      = slaveOn ? s_data_in : h_wdata_in;
      checkOutput("mdl_gnt", h_gnt_out, mGnt);
      checkOutput("mdl_wr", ram_wr_en_out, mWr);
      checkOutput("mdl_rd", ram_rd_en_out, mRd);
      checkOutput("mdl_addr", ram_addr_out, mAddr);
      checkOutput("mdl_data", ram_data_out, mData);
      checkOutput("mdl_sdata", s_data_out, pendS ? pendSVal : heldS);
      checkOutput("mdl_hdata", h_rdata_out, pendH ? pendHVal : heldH);
      checkOutput("mdl_rvalid", h_rvalid_out, pendH);
      checkOutput("mdl_starve", h_starve_out, 32'(waitCnt >= STARVE_LIMIT));
    end

    @(posedge clock_in);
    if (live) begin
      if (pendS) heldS = pendSVal;
      if (pendH) heldH = pendHVal;
      pendS    = mSlaveRead;
      pendH    = mHostRead;
      pendSVal = expMem[mAddr];
      pendHVal = expMem[mAddr];
      if (mWr) expMem[mAddr] = mData;
      if (h_req_in && !mGnt) waitCnt = (waitCnt < WAIT_MAX) ? waitCnt + 1 : WAIT_MAX;
      else waitCnt = 0;
    end
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, want finish before t=100000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    #2 reset_in = 1'b0;

    // Reset held while both ports request
    applyStimulus(1'b0, 1'b1, 7'h03, 8'h00, 1'b1, 1'b0, 7'h12, 8'h00);
    @(negedge clock_in);
    checkOutput("rst_gnt", h_gnt_out, 0);
    checkOutput("rst_rd", ram_rd_en_out, 0);
    checkOutput("rst_sdata", s_data_out, 0);
    applyStimulus(1'b1, 1'b0, 7'h04, 8'h55, 1'b1, 1'b1, 7'h12, 8'h66);
    @(negedge clock_in);
    checkOutput("rst_wr", ram_wr_en_out, 0);
    checkOutput("rst_starve", h_starve_out, 0);
    idleCycle();
    reset_in = 1'b1;
    @(negedge clock_in);
    checkOutput("rel_rvalid0", h_rvalid_out, 0);
    idleCycle();
    @(negedge clock_in);
    checkOutput("rel_rvalid1", h_rvalid_out, 0);

    // Host only: write 0xA5 to 0x12, then read it back
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 7'h12, 8'hA5);
    @(negedge clock_in);
    checkOutput("hw_gnt", h_gnt_out, 1);
    checkOutput("hw_wr", ram_wr_en_out, 1);
    checkOutput("hw_addr", ram_addr_out, 32'h12);
    checkOutput("hw_data", ram_data_out, 32'hA5);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 7'h12, 8'h00);
    @(negedge clock_in);
    checkOutput("hr_gnt", h_gnt_out, 1);
    checkOutput("hr_rd", ram_rd_en_out, 1);
    idleCycle();
    @(negedge clock_in);
    checkOutput("hr_rvalid", h_rvalid_out, 1);
    checkOutput("hr_rdata", h_rdata_out, 32'hA5);
    idleCycle();
    @(negedge clock_in);
    checkOutput("hr_rvalid_drop", h_rvalid_out, 0);
    checkOutput("hr_rdata_hold", h_rdata_out, 32'hA5);

    // Collision: slave writes 0x3C to 0x05 while host waits to read 0x05
    applyStimulus(1'b1, 1'b0, 7'h05, 8'h3C, 1'b1, 1'b0, 7'h05, 8'h00);
    @(negedge clock_in);
    checkOutput("col_gnt_n", h_gnt_out, 0);
    checkOutput("col_wr", ram_wr_en_out, 1);
    checkOutput("col_rd", ram_rd_en_out, 0);
    checkOutput("col_addr", ram_addr_out, 32'h05);
    checkOutput("col_data", ram_data_out, 32'h3C);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 7'h05, 8'h00);
    @(negedge clock_in);
    checkOutput("col_gnt_n1", h_gnt_out, 1);
    idleCycle();
    @(negedge clock_in);
    checkOutput("col_rvalid", h_rvalid_out, 1);
    checkOutput("col_rdata", h_rdata_out, 32'h3C);

    // Interleaved reads: preload 0x01=0x11, 0x02=0x22
    applyStimulus(1'b1, 1'b0, 7'h01, 8'h11, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, 7'h02, 8'h22, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b1, 7'h01, 8'h00, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 7'h02, 8'h00);
    @(negedge clock_in);
    checkOutput("il_sdata_n1", s_data_out, 32'h11);
    checkOutput("il_gnt_n1", h_gnt_out, 1);
    idleCycle();
    @(negedge clock_in);
    checkOutput("il_rvalid_n2", h_rvalid_out, 1);
    checkOutput("il_rdata_n2", h_rdata_out, 32'h22);
    checkOutput("il_sdata_n2", s_data_out, 32'h11);

    // Starvation: 12 slave cycles with the host requesting
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1'b1, 1'b0, 7'(8'h40 + i), 8'(i), 1'b1, 1'b1, 7'h50, 8'h99);
      @(negedge clock_in);
      checkOutput($sformatf("stv_starve_c%0d", i), h_starve_out, 32'(i >= 9));
      checkOutput($sformatf("stv_gnt_c%0d", i), h_gnt_out, 0);
    end
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 7'h50, 8'h99);
    @(negedge clock_in);
    checkOutput("stv_gnt_c13", h_gnt_out, 1);
    checkOutput("stv_starve_c13", h_starve_out, 1);
    idleCycle();
    @(negedge clock_in);
    checkOutput("stv_starve_c14", h_starve_out, 0);

    // Long starvation past counter saturation
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, 1'b0, 7'h60, 8'(i), 1'b1, 1'b1, 7'h51, 8'h98);
    end
    @(negedge clock_in);
    checkOutput("sat_starve_c20", h_starve_out, 1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 7'h51, 8'h98);
    idleCycle();
    @(negedge clock_in);
    checkOutput("sat_starve_clear", h_starve_out, 0);

    // Illegal slave strobe combination: write wins, no read return
    applyStimulus(1'b1, 1'b1, 7'h30, 8'h77, 1'b0, 1'b0, '0, '0);
    @(negedge clock_in);
    checkOutput("ill_wr", ram_wr_en_out, 1);
    checkOutput("ill_rd", ram_rd_en_out, 0);
    checkOutput("ill_addr", ram_addr_out, 32'h30);
    checkOutput("ill_data", ram_data_out, 32'h77);
    idleCycle();
    @(negedge clock_in);
    checkOutput("ill_sdata", s_data_out, 32'h11);
    checkOutput("ill_rvalid", h_rvalid_out, 0);

    // Reset in the middle of a host read drops the return
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 7'h12, 8'h00);
    idleCycle();
    reset_in = 1'b0;
    @(negedge clock_in);
    checkOutput("mrr_rvalid", h_rvalid_out, 0);
    checkOutput("mrr_rdata", h_rdata_out, 0);
    idleCycle();
    reset_in = 1'b1;
    @(negedge clock_in);
    checkOutput("mrr_rvalid_rel", h_rvalid_out, 0);
    checkOutput("mrr_sdata_rel", s_data_out, 0);

    // Back-to-back reads chain host, host, slave
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 7'h05, 8'h00);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 7'h12, 8'h00);
    @(negedge clock_in);
    checkOutput("chn_gnt_b", h_gnt_out, 1);
    checkOutput("chn_rvalid_b", h_rvalid_out, 1);
    checkOutput("chn_rdata_b", h_rdata_out, 32'h3C);
    applyStimulus(1'b0, 1'b1, 7'h02, 8'h00, 1'b0, 1'b0, '0, '0);
    @(negedge clock_in);
    checkOutput("chn_rvalid_c", h_rvalid_out, 1);
    checkOutput("chn_rdata_c", h_rdata_out, 32'hA5);
    idleCycle();
    @(negedge clock_in);
    checkOutput("chn_sdata_d", s_data_out, 32'h22);
    checkOutput("chn_rvalid_d", h_rvalid_out, 0);
    checkOutput("chn_rdata_d", h_rdata_out, 32'hA5);

    idleCycle();
    idleCycle();
    @(negedge clock_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
